// File: rtl/tube_readback.sv
// tube_readback: receive side of the scanned 7-segment tube bus. Decodes each
// digit to a 3-bit code and one-hot value after STABLE identical samples.
// Ports: clk, rst (sync, active high), sample_en, tube[6:0] (active low,
//   bit6=a..bit0=g), an[DIGITS-1:0] (active-low digit select);
//   code3/onehot/valid/err per digit, upd per-digit change pulse,
//   bus_err pulse for more than one active digit select.
// Option: TUBE_ERR_CNT_EN adds err_cnt[7:0] (ILLEGAL commits + bus errors).
module tube_readback #(
  parameter int DIGITS = 4,
  parameter int STABLE = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_en,
  input  logic [6:0]            tube,
  input  logic [DIGITS-1:0]     an,
  output logic [3*DIGITS-1:0]   code3,
  output logic [8*DIGITS-1:0]   onehot,
  output logic [DIGITS-1:0]     valid,
  output logic [DIGITS-1:0]     err,
  output logic [DIGITS-1:0]     upd,
`ifdef TUBE_ERR_CNT_EN
  output logic [7:0]            err_cnt,
`endif
  output logic                  bus_err
);

  localparam int CW = (STABLE < 2) ? 1 : $clog2(STABLE + 1);
  localparam logic [CW-1:0] ST = CW'(STABLE);
  localparam logic [3:0] BLANK = 4'd8;
  localparam logic [3:0] ILL   = 4'd9;

  logic [3:0]          cls;
  logic                one_low;
  logic                many_low;
  logic [DIGITS-1:0]   hit;
  logic [DIGITS-1:0]   commit;
  logic [3:0]          cand_q [DIGITS];
  logic [3:0]          cand_d [DIGITS];
  logic [3:0]          com_q  [DIGITS];
  logic [CW-1:0]       cnt_q  [DIGITS];
  logic [CW-1:0]       cnt_d  [DIGITS];
  logic [3*DIGITS-1:0] code3_q;
  logic [8*DIGITS-1:0] onehot_q;
  logic [DIGITS-1:0]   valid_q;
  logic [DIGITS-1:0]   err_q;
  logic [DIGITS-1:0]   upd_q;
  logic                bus_err_q;

  // Classes 0..7 are codes, 8 is blank, 9 is anything else.
  always_comb begin
    case (tube)
      7'b0000001: cls = 4'd0;
      7'b1001111: cls = 4'd1;
      7'b0010010: cls = 4'd2;
      7'b0000110: cls = 4'd3;
      7'b1001100: cls = 4'd4;
      7'b0100100: cls = 4'd5;
      7'b0100000: cls = 4'd6;
      7'b0001111: cls = 4'd7;
      7'b1111111: cls = BLANK;
      default:    cls = ILL;
    endcase
  end

  always_comb begin
    one_low  = ($countones(~an) == 1);
    many_low = ($countones(~an) > 1);
  end

  // Commit only on the sample that reaches STABLE; saturated repeats
  // are silent.
  always_comb begin
    for (int d = 0; d < DIGITS; d++) begin
      hit[d]    = sample_en && one_low && !an[d];
      cand_d[d] = cand_q[d];
      cnt_d[d]  = cnt_q[d];
      commit[d] = 1'b0;
      if (hit[d]) begin
        if (cls == cand_q[d]) begin
          if (cnt_q[d] != ST) begin
            cnt_d[d]  = cnt_q[d] + 1'b1;
            commit[d] = (cnt_d[d] == ST);
          end
        end else begin
          cand_d[d] = cls;
          cnt_d[d]  = CW'(1);
          commit[d] = (STABLE == 1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int d = 0; d < DIGITS; d++) begin
        cand_q[d] <= BLANK;
        com_q[d]  <= BLANK;
        cnt_q[d]  <= '0;
      end
      code3_q   <= '0;
      onehot_q  <= '0;
      valid_q   <= '0;
      err_q     <= '0;
      upd_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= sample_en && many_low;
      upd_q     <= '0;
      for (int d = 0; d < DIGITS; d++) begin
        cand_q[d] <= cand_d[d];
        cnt_q[d]  <= cnt_d[d];
        if (commit[d]) begin
          com_q[d]   <= cls;
          upd_q[d]   <= (cls != com_q[d]);
          valid_q[d] <= !cls[3];
          err_q[d]   <= (cls == ILL);
          if (!cls[3]) begin
            code3_q[3*d +: 3]  <= cls[2:0];
            onehot_q[8*d +: 8] <= 8'b1 << cls[2:0];
          end else begin
            onehot_q[8*d +: 8] <= '0;
          end
        end
      end
    end
  end

`ifdef TUBE_ERR_CNT_EN
  logic [7:0] err_cnt_q;
  logic       ill_cmt;
  logic [8:0] err_sum;

  // Counts the bus_err pulse itself, so it can coincide with a commit.
  always_comb begin
    ill_cmt = (|commit) && (cls == ILL);
    err_sum = {1'b0, err_cnt_q} + 9'(ill_cmt) + 9'(bus_err_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_sum[8] ? 8'hFF : err_sum[7:0];
    end
  end

  assign err_cnt = err_cnt_q;
`endif

  assign code3   = code3_q;
  assign onehot  = onehot_q;
  assign valid   = valid_q;
  assign err     = err_q;
  assign upd     = upd_q;
  assign bus_err = bus_err_q;

endmodule
